// File: rtl/text_line_overlay.sv
// One-line text overlay sequencer: maps raster pixels to character cells, drives the 8x8 font ROM
// and registers the selected glyph bit two clocks after the pixel. Optional blink: `TEXT_BLINK_EN.
module text_line_overlay #(
  parameter int NCHAR      = 16,
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter int SCALE_LOG2 = 0,
  parameter int XW         = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(NCHAR)-1:0] wr_addr,
  input  logic [7:0]               wr_data,
  input  logic                     wr_attr,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [XW-1:0]            pix_x,
  input  logic [XW-1:0]            pix_y,
  output logic [7:0]               font_char,
  output logic [2:0]               font_row,
  input  logic [7:0]               font_bits,
  output logic                     ovl_valid,
  output logic                     ovl_on,
  output logic                     ovl_in_region
);

  localparam int IW = $clog2(NCHAR);
  localparam int DW = XW + 1;
  localparam int CS = 3 + SCALE_LOG2;
  localparam logic [DW-1:0] X0_D  = DW'(X0);
  localparam logic [DW-1:0] Y0_D  = DW'(Y0);
  localparam logic [DW-1:0] REG_W = DW'(NCHAR << CS);
  localparam logic [DW-1:0] REG_H = DW'(8 << SCALE_LOG2);
  localparam logic [7:0]    SPACE = 8'h20;

  logic [DW-1:0] px, py, dx, dy;
  logic          in_region;

  // Offsets carry one extra bit so an inside-region pixel never wraps negative.
  assign px        = {1'b0, pix_x};
  assign py        = {1'b0, pix_y};
  assign dx        = px - X0_D;
  assign dy        = py - Y0_D;
  assign in_region = (px >= X0_D) && (dx < REG_W) && (py >= Y0_D) && (dy < REG_H);

  logic          s1_valid;
  logic          s1_in_region;
  logic [IW-1:0] s1_idx;
  logic [2:0]    s1_col;
  logic [2:0]    s1_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_in_region <= 1'b0;
      s1_idx       <= '0;
      s1_col       <= '0;
      s1_row       <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_in_region <= in_region;
        s1_idx       <= dx[CS+IW-1:CS];
        s1_col       <= dx[SCALE_LOG2+2:SCALE_LOG2];
        s1_row       <= dy[SCALE_LOG2+2:SCALE_LOG2];
      end
    end
  end

  logic [7:0] txt_code [NCHAR];

  // NOTE: the buffer must come out of reset holding spaces, so it is built from
  // resettable flops rather than a RAM macro; that is why it sits in this async-reset block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHAR; i++) txt_code[i] <= SPACE;
    end else if (wr_en) begin
      txt_code[wr_addr] <= wr_data;
    end
  end

  // ROM address comes purely from S1 flops; a same-cycle write is seen by the next pixel.
  assign font_char = s1_in_region ? txt_code[s1_idx] : SPACE;
  assign font_row  = s1_row;

  logic blank;

`ifdef TEXT_BLINK_EN
  logic       txt_attr [NCHAR];
  logic [5:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHAR; i++) txt_attr[i] <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (wr_en) txt_attr[wr_addr] <= wr_attr;
      if (frame_start) frame_cnt <= frame_cnt + 6'd1;
    end
  end

  assign blank = txt_attr[s1_idx] & frame_cnt[5];
`else
  logic unused_blink;
  assign unused_blink = ^{wr_attr, frame_start};
  assign blank        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovl_valid     <= 1'b0;
      ovl_on        <= 1'b0;
      ovl_in_region <= 1'b0;
    end else begin
      ovl_valid     <= s1_valid;
      ovl_in_region <= s1_valid & s1_in_region;
      ovl_on        <= s1_valid & s1_in_region & font_bits[3'd7 - s1_col] & ~blank;
    end
  end

endmodule

// File: tb/tb_text_line_overlay.sv
// Self-checking bench for text_line_overlay: default instance plus a 2x-scaled, offset instance,
// both compared every cycle against a pixel-level reference model.
module tb_text_line_overlay;

  localparam int NCHAR = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = 8'h20;
  logic        wr_attr = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [10:0] pix_x = '0;
  logic [10:0] pix_y = '0;

  logic [7:0] fc0, fc1, fb0, fb1;
  logic [2:0] fr0, fr1;
  logic       ov0, on0, ir0, ov1, on1, ir1;

  always #5 clk = ~clk;

  // Font ROM model: known glyphs for space, 'T' and 'E'; a hash pattern for everything else.
  function automatic logic [7:0] rom(input logic [7:0] c, input logic [2:0] r);
    int h;
    case (c)
      8'h20: return 8'h00;
      8'h54: case (r)
               3'd0, 3'd7: return 8'h00;
               3'd1:       return 8'h7E;
               default:    return 8'h18;
             endcase
      8'h45: case (r)
               3'd0, 3'd7: return 8'h00;
               3'd1, 3'd6: return 8'hFE;
               3'd3:       return 8'hFC;
               default:    return 8'hC0;
             endcase
      default: begin
        h = int'(c) * 37 + int'(r) * 91 + 13;
        return h[7:0] ^ 8'h5A;
      end
    endcase
  endfunction

  assign fb0 = rom(fc0, fr0);
  assign fb1 = rom(fc1, fr1);

  text_line_overlay #(.NCHAR(16), .X0(0), .Y0(0), .SCALE_LOG2(0), .XW(11)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_attr(wr_attr), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .font_char(fc0), .font_row(fr0), .font_bits(fb0),
    .ovl_valid(ov0), .ovl_on(on0), .ovl_in_region(ir0));

  text_line_overlay #(.NCHAR(16), .X0(100), .Y0(50), .SCALE_LOG2(1), .XW(11)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_attr(wr_attr), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .font_char(fc1), .font_row(fr1), .font_bits(fb1),
    .ovl_valid(ov1), .ovl_on(on1), .ovl_in_region(ir1));

  typedef struct packed { bit v; bit in; bit on; } exp_t;
  typedef struct packed { bit in; int idx; int row; } s1m_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mbuf [NCHAR];
  bit         mattr [NCHAR];
  int         mframe;
  exp_t       q0[$], q1[$];
  s1m_t       m0, m1;
  logic [7:0] seq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit blank_of(input int idx);
`ifdef TEXT_BLINK_EN
    return mattr[idx] && mframe[5];
`else
    return (idx < 0);
`endif
  endfunction

  // What the overlay should show for pixel (x,y) on an instance with the given geometry.
  function automatic exp_t model_pixel(input bit v, input int x, input int y, input int x0,
                                       input int y0, input int s, inout s1m_t m);
    int cw, idx, col, row;
    bit in;
    logic [7:0] bits;
    exp_t e;
    cw   = 8 << s;
    in   = (x >= x0) && (x < x0 + NCHAR * cw) && (y >= y0) && (y < y0 + cw);
    idx  = in ? (x - x0) / cw : 0;
    col  = ((x - x0) >> s) & 7;
    row  = ((y - y0) >> s) & 7;
    bits = rom(mbuf[idx], 3'(row));
    e.v  = v;
    e.in = v && in;
    e.on = v && in && bits[7 - col] && !blank_of(idx);
    if (v) begin
      m.in  = in;
      m.idx = idx;
      m.row = row;
    end
    return e;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NCHAR; i++) begin
      mbuf[i]  = 8'h20;
      mattr[i] = 1'b0;
    end
    mframe = 0;
    q0 = {};
    q1 = {};
    q0.push_back('0);
    q1.push_back('0);
    m0 = '0;
    m1 = '0;
  endtask

  task automatic step(input bit v, input int x, input int y, input bit we = 0, input int wa = 0,
                      input logic [7:0] wd = 8'h20, input bit wat = 0, input bit fs = 0);
    exp_t e0, e1;
    pix_valid   = v;
    pix_x       = 11'(x);
    pix_y       = 11'(y);
    wr_en       = we;
    wr_addr     = 4'(wa);
    wr_data     = wd;
    wr_attr     = wat;
    frame_start = fs;
    if (we) begin
      mbuf[wa]  = wd;
      mattr[wa] = wat;
    end
    if (fs) mframe = (mframe + 1) % 64;
    q0.push_back(model_pixel(v, x, y, 0, 0, 0, m0));
    q1.push_back(model_pixel(v, x, y, 100, 50, 1, m1));
    @(posedge clk);
    #1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    check("ovl_valid0", 32'(ov0), 32'(e0.v));
    check("ovl_in_region0", 32'(ir0), 32'(e0.in));
    check("ovl_on0", 32'(on0), 32'(e0.on));
    check("font_char0", 32'(fc0), 32'(m0.in ? mbuf[m0.idx] : 8'h20));
    check("font_row0", 32'(fr0), 32'(m0.row));
    check("ovl_valid1", 32'(ov1), 32'(e1.v));
    check("ovl_in_region1", 32'(ir1), 32'(e1.in));
    check("ovl_on1", 32'(on1), 32'(e1.on));
    check("font_char1", 32'(fc1), 32'(m1.in ? mbuf[m1.idx] : 8'h20));
    check("font_row1", 32'(fr1), 32'(m1.row));
  endtask

  task automatic do_reset();
    pix_valid   = 1'b0;
    wr_en       = 1'b0;
    frame_start = 1'b0;
    rst_n       = 1'b0;
    reset_model();
    #1;
    check("rst ovl_valid0", 32'(ov0), 0);
    check("rst ovl_on0", 32'(on0), 0);
    check("rst ovl_in_region0", 32'(ir0), 0);
    check("rst font_char0", 32'(fc0), 32'h20);
    check("rst font_row0", 32'(fr0), 0);
    check("rst ovl_valid1", 32'(ov1), 0);
    check("rst ovl_on1", 32'(on1), 0);
    check("rst ovl_in_region1", 32'(ir1), 0);
    check("rst font_char1", 32'(fc1), 32'h20);
    check("rst font_row1", 32'(fr1), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    do_reset();

    // Full raster over and around the default text region: buffer holds spaces.
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 160; x++) step(1, x, y);

    // 'T' in cell 0, glyph row 1.
    step(0, 0, 0, 1, 0, 8'h54);
    seq = '0;
    for (int i = 0; i < 9; i++) begin
      step(i < 8, i, 1);
      if (i > 0) seq = {seq[6:0], on0};
    end
    check("T row1 sequence", 32'(seq), 32'h7E);

    // Write cell 3 while S1 reads it: that pixel sees the old code, the next the new one.
    step(0, 0, 0, 1, 3, 8'h45);
    step(1, 24, 1);
    step(1, 24, 1, 1, 3, 8'h54);
    check("same-cycle old code", 32'(on0), 1);
    step(0, 0, 0);
    check("next pixel new code", 32'(on0), 0);

    // Scaled instance: 'E' in cell 1, pixel (117,52).
    step(0, 0, 0, 1, 1, 8'h45);
    step(1, 117, 52);
    check("scaled font_char", 32'(fc1), 32'h45);
    check("scaled font_row", 32'(fr1), 1);
    step(0, 0, 0);
    check("scaled ovl_on", 32'(on1), 1);
    check("scaled ovl_in_region", 32'(ir1), 1);

    // Randomized traffic with writes, gaps and frame pulses.
    for (int i = 0; i < 3000; i++) begin
      int x, y, sel;
      logic [7:0] wd;
      if ($urandom_range(0, 1) == 1) begin
        x = $urandom_range(0, 200);
        y = $urandom_range(0, 12);
      end else begin
        x = $urandom_range(80, 380);
        y = $urandom_range(40, 70);
      end
      if ($urandom_range(0, 63) == 0) x = 2047;
      sel = $urandom_range(0, 3);
      wd  = (sel == 0) ? 8'h54 : (sel == 1) ? 8'h45 : (sel == 2) ? 8'h20 : 8'($urandom);
      step($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 7) == 0,
           $urandom_range(0, NCHAR - 1), wd, 1'($urandom), $urandom_range(0, 15) == 0);
    end

    // pix_valid 1,0,1 then a reset with a pixel still in flight.
    step(1, 10, 1);
    step(0, 11, 1);
    check("valid hole 1", 32'(ov0), 1);
    step(1, 12, 1);
    check("valid hole 0", 32'(ov0), 0);
    step(1, 13, 1);
    check("valid hole 1 again", 32'(ov0), 1);
    do_reset();
    for (int x = 0; x < 130; x++) step(1, x, 1);
    step(1, 117, 52);
    step(0, 0, 0);

`ifdef TEXT_BLINK_EN
    do_reset();
    step(0, 0, 0, 1, 0, 8'h54, 1);
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 0, 8'h20, 0, 1);
    step(1, 1, 1);
    step(0, 0, 0);
    check("blink off in_region", 32'(ir0), 1);
    check("blink off pixel", 32'(on0), 0);
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 0, 8'h20, 0, 1);
    step(1, 1, 1);
    step(0, 0, 0);
    check("blink on pixel", 32'(on0), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
